// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, turning static decoder fields into per-cycle strobes.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             dec_mr,
  input  logic             dec_mw,
  input  logic             dec_rw,
  input  logic             dec_jl,
  input  logic             dec_jlr,
  input  logic             dec_br,
  input  logic             dec_illegal,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_ld,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             rf_we,
  output logic             pc_ld,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // The counter only ever needs to hold TIMEOUT-1: the cycle it would reach TIMEOUT we trap.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            cur;
  state_t            nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timed_out;

  assign waiting   = ((cur == S_FETCH) && !imem_ack) || ((cur == S_MEM) && !dmem_ack);
  assign timed_out = (TIMEOUT > 0) && waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign state     = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Wait counter is zero outside handshake stalls, so it is already clear on entry to FETCH/MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
      if (cur == S_WB) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt      = cur;
    imem_req = 1'b0;
    ir_ld    = 1'b0;
    dmem_rd  = 1'b0;
    dmem_wr  = 1'b0;
    rf_we    = 1'b0;
    pc_ld    = 1'b0;
    pc_sel   = 2'd0;
    trap     = 1'b0;
    case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_ld    = imem_ack;
        if (imem_ack) nxt = S_DECODE;
        else if (timed_out) nxt = S_TRAP;
      end
      S_DECODE: begin
        nxt = (dec_illegal || (dec_mr && dec_mw)) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        nxt = (dec_mr || dec_mw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_rd = dec_mr;
        dmem_wr = dec_mw;
        if (dmem_ack) nxt = S_WB;
        else if (timed_out) nxt = S_TRAP;
      end
      S_WB: begin
        rf_we = dec_rw;
        pc_ld = 1'b1;
        // jalr wins over jal so a decoder asserting both still targets rs1+imm.
        if (dec_jlr) pc_sel = 2'd2;
        else if (dec_jl || (dec_br && br_taken)) pc_sel = 2'd1;
        nxt = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected cycle trace, which is compared against the DUT.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic dec_mr = 1'b0, dec_mw = 1'b0, dec_rw = 1'b0, dec_jl = 1'b0, dec_jlr = 1'b0;
  logic dec_br = 1'b0, dec_illegal = 1'b0, br_taken = 1'b0;

  logic       imem_req, ir_ld, dmem_rd, dmem_wr, rf_we, pc_ld, trap;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [3:0] instret;

  logic       req0, irld0, rd0, wr0, we0, pcld0, trap0;
  logic [1:0] sel0;
  logic [2:0] state0;
  logic [3:0] instret0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .dec_mr(dec_mr), .dec_mw(dec_mw), .dec_rw(dec_rw), .dec_jl(dec_jl), .dec_jlr(dec_jlr),
    .dec_br(dec_br), .dec_illegal(dec_illegal), .br_taken(br_taken),
    .imem_req(imem_req), .ir_ld(ir_ld), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .rf_we(rf_we), .pc_ld(pc_ld), .pc_sel(pc_sel), .state(state), .instret(instret),
    .trap(trap)
  );

  multicycle_ctrl #(.TIMEOUT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .dec_mr(dec_mr), .dec_mw(dec_mw), .dec_rw(dec_rw), .dec_jl(dec_jl), .dec_jlr(dec_jlr),
    .dec_br(dec_br), .dec_illegal(dec_illegal), .br_taken(br_taken),
    .imem_req(req0), .ir_ld(irld0), .dmem_rd(rd0), .dmem_wr(wr0),
    .rf_we(we0), .pc_ld(pcld0), .pc_sel(sel0), .state(state0), .instret(instret0),
    .trap(trap0)
  );

  typedef struct packed {
    logic run, imem_ack, dmem_ack, mr, mw, rw, jl, jlr, br, illegal, taken;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic       req, ir, rd, wr, we, pcld;
    logic [1:0] sel;
    logic       trap;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    logic mr, mw, rw, jl, jlr, br, taken;
    int   iw, dw;
    bit   drop;
  } instr_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  obs_t  act_q[$];
  logic [3:0] m_instret = 4'd0;
  bit         m_idle = 1'b1;

  function automatic stim_t rnd_stim(input logic r);
    stim_t s;
    s = stim_t'(11'($urandom));
    s.run = r;
    return s;
  endfunction

  function automatic instr_t mk(input logic mr, mw, rw, jl, jlr, br, taken,
                                input int iw, dw, input bit drop);
    instr_t in;
    in.mr = mr; in.mw = mw; in.rw = rw; in.jl = jl; in.jlr = jlr; in.br = br;
    in.taken = taken; in.iw = iw; in.dw = dw; in.drop = drop;
    return in;
  endfunction

  function automatic stim_t dec_stim(input instr_t in, input logic r);
    stim_t s;
    s = rnd_stim(r);
    s.mr = in.mr; s.mw = in.mw; s.rw = in.rw; s.jl = in.jl; s.jlr = in.jlr;
    s.br = in.br; s.taken = in.taken; s.illegal = 1'b0;
    return s;
  endfunction

  function automatic void add(input stim_t s, input obs_t e);
    obs_t x;
    x = e;
    x.cnt = m_instret;
    stim_q.push_back(s);
    exp_q.push_back(x);
  endfunction

  function automatic obs_t ob(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic void model_idle(input int n);
    for (int k = 0; k < n; k++) add(rnd_stim(1'b0), ob(3'd0));
  endfunction

  function automatic void model_start();
    if (m_idle) begin
      add(rnd_stim(1'b1), ob(3'd0));
      m_idle = 1'b0;
    end
  endfunction

  function automatic void model_fetch(input int iw, input int stall);
    stim_t s;
    obs_t  e;
    for (int k = 0; k <= iw; k++) begin
      s = rnd_stim(1'b1);
      s.imem_ack = (stall == 0) && (k == iw);
      e = ob(3'd1); e.req = 1'b1; e.ir = s.imem_ack;
      add(s, e);
    end
  endfunction

  // One instruction retired: fetch, decode, execute, optional memory, writeback.
  function automatic void model_instr(input instr_t in);
    stim_t s;
    obs_t  e;
    model_start();
    model_fetch(in.iw, 0);
    add(dec_stim(in, 1'b1), ob(3'd2));
    add(dec_stim(in, !in.drop), ob(3'd3));
    if (in.mr || in.mw) begin
      for (int k = 0; k <= in.dw; k++) begin
        s = dec_stim(in, !in.drop);
        s.dmem_ack = (k == in.dw);
        e = ob(3'd4); e.rd = in.mr; e.wr = in.mw;
        add(s, e);
      end
    end
    e = ob(3'd5); e.we = in.rw; e.pcld = 1'b1;
    e.sel = in.jlr ? 2'd2 : ((in.jl || (in.br && in.taken)) ? 2'd1 : 2'd0);
    add(dec_stim(in, !in.drop), e);
    m_instret = m_instret + 4'd1;
    if (in.drop) m_idle = 1'b1;
  endfunction

  function automatic void model_trapped(input int n);
    obs_t e;
    e = ob(3'd6); e.trap = 1'b1;
    for (int k = 0; k < n; k++) add(rnd_stim(1'($urandom)), e);
  endfunction

  function automatic void model_mem_stall(input int n);
    instr_t in;
    stim_t  s;
    obs_t   e;
    in = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    model_start();
    model_fetch(0, 0);
    add(dec_stim(in, 1'b1), ob(3'd2));
    add(dec_stim(in, 1'b1), ob(3'd3));
    for (int k = 0; k < n; k++) begin
      s = dec_stim(in, 1'b1);
      s.dmem_ack = 1'b0;
      e = ob(3'd4); e.rd = 1'b1;
      add(s, e);
    end
  endfunction

  function automatic void model_decode_trap(input logic ill, input logic both);
    instr_t in;
    stim_t  s;
    in = mk(both, both, 1, 0, 0, 0, 0, 0, 0, 0);
    model_start();
    model_fetch(int'($urandom_range(0, 2)), 0);
    s = dec_stim(in, 1'b1);
    s.illegal = ill;
    add(s, ob(3'd2));
  endfunction

  function automatic obs_t sample();
    return obs_t'({state, imem_req, ir_ld, dmem_rd, dmem_wr, rf_we, pc_ld, pc_sel, trap, instret});
  endfunction

  task automatic drive(input stim_t s);
    {run, imem_ack, dmem_ack, dec_mr, dec_mw, dec_rw, dec_jl, dec_jlr, dec_br,
     dec_illegal, br_taken} = s;
  endtask

  task automatic play();
    foreach (stim_q[i]) begin
      @(negedge clk);
      drive(stim_q[i]);
      #1;
      act_q.push_back(sample());
    end
    stim_q.delete();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    drive(stim_t'(11'd0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_instret = 4'd0;
    m_idle = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    drive(stim_t'(11'h7ff));
    repeat (2) @(negedge clk);
    #1 o = sample();
    total++;
    if (o !== obs_t'(16'd0)) $display("[TB] FAIL reset_hold: got %h expected %h", o, 16'd0);
    else passed++;
    drive(stim_t'(11'd0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 o = sample();
    total++;
    if (o !== obs_t'(16'd0)) $display("[TB] FAIL reset_idle: got %h expected %h", o, 16'd0);
    else passed++;
  endtask

  task automatic test_add();
    act_q.delete(); exp_q.delete();
    model_instr(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    model_instr(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    model_idle(2);
    play();
    foreach (exp_q[i]) begin
      total++;
      if (act_q[i] !== exp_q[i])
        $display("[TB] FAIL add cyc %0d: got st=%0d out=%h expected st=%0d out=%h",
                 i, act_q[i].st, act_q[i], exp_q[i].st, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_load_wait();
    act_q.delete(); exp_q.delete();
    model_instr(mk(1, 0, 1, 0, 0, 0, 0, 0, 3, 1));
    model_idle(2);
    play();
    foreach (exp_q[i]) begin
      total++;
      if (act_q[i] !== exp_q[i])
        $display("[TB] FAIL load cyc %0d: got st=%0d out=%h expected st=%0d out=%h",
                 i, act_q[i].st, act_q[i], exp_q[i].st, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_branch_jump();
    act_q.delete(); exp_q.delete();
    model_instr(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    model_instr(mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    model_instr(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    model_instr(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    model_idle(2);
    play();
    foreach (exp_q[i]) begin
      total++;
      if (act_q[i] !== exp_q[i])
        $display("[TB] FAIL branch cyc %0d: got st=%0d out=%h expected st=%0d out=%h",
                 i, act_q[i].st, act_q[i], exp_q[i].st, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_run_drop();
    act_q.delete(); exp_q.delete();
    model_instr(mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 1));
    model_idle(3);
    model_instr(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    model_idle(2);
    play();
    foreach (exp_q[i]) begin
      total++;
      if (act_q[i] !== exp_q[i])
        $display("[TB] FAIL run_drop cyc %0d: got st=%0d out=%h expected st=%0d out=%h",
                 i, act_q[i].st, act_q[i], exp_q[i].st, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    instr_t in;
    int     kind;
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 5));
      in = mk(kind == 1, kind == 2, kind inside {0, 1, 4, 5}, kind == 4, kind == 5,
              kind == 3, 1'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), (n == 29) || ($urandom_range(0, 4) == 0));
      model_instr(in);
      if (in.drop) model_idle(int'($urandom_range(0, 3)));
    end
    model_idle(2);
    play();
    foreach (exp_q[i]) begin
      total++;
      if (act_q[i] !== exp_q[i])
        $display("[TB] FAIL random cyc %0d: got st=%0d out=%h expected st=%0d out=%h",
                 i, act_q[i].st, act_q[i], exp_q[i].st, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_trap();
    obs_t o;
    act_q.delete(); exp_q.delete();
    do_reset();
    model_decode_trap(1'b1, 1'b0);
    model_trapped(8);
    play();
    #2 rst_n = 1'b0;
    #1 o = sample();
    total++;
    if (o !== obs_t'(16'd0)) $display("[TB] FAIL async_reset_trap: got %h expected %h", o, 16'd0);
    else passed++;
    do_reset();
    model_decode_trap(1'b0, 1'b1);
    model_trapped(8);
    play();
    do_reset();
    foreach (exp_q[i]) begin
      total++;
      if (act_q[i] !== exp_q[i])
        $display("[TB] FAIL trap cyc %0d: got st=%0d out=%h expected st=%0d out=%h",
                 i, act_q[i].st, act_q[i], exp_q[i].st, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    act_q.delete(); exp_q.delete();
    do_reset();
    model_start();
    model_fetch(15, 1);
    model_trapped(5);
    play();
    do_reset();
    model_mem_stall(16);
    model_trapped(5);
    play();
    do_reset();
    model_mem_stall(3);
    play();
    #2 rst_n = 1'b0;
    #1 o = sample();
    total++;
    if (o !== obs_t'(16'd0)) $display("[TB] FAIL async_reset_mem: got %h expected %h", o, 16'd0);
    else passed++;
    do_reset();
    foreach (exp_q[i]) begin
      total++;
      if (act_q[i] !== exp_q[i])
        $display("[TB] FAIL timeout cyc %0d: got st=%0d out=%h expected st=%0d out=%h",
                 i, act_q[i].st, act_q[i], exp_q[i].st, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout_disabled();
    logic [15:0] got;
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      run = 1'b1;
      imem_ack = 1'b0;
      #1;
      if (c % 10 == 0) begin
        got = {state0, req0, irld0, rd0, wr0, we0, pcld0, sel0, trap0, instret0};
        total++;
        if (got !== {3'd1, 1'b1, 12'd0})
          $display("[TB] FAIL no_timeout cyc %0d: got %h expected %h", c, got, {3'd1, 1'b1, 12'd0});
        else passed++;
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch_jump();
    test_run_drop();
    test_random();
    test_trap();
    test_timeout();
    test_timeout_disabled();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
